seg_scan_ndigit: RTL and testbench
==================================

# seg_scan_ndigit

Parametrised multiplexed driver for an N-digit common-electrode 7-segment display. It converts N packed 4-bit hex digit values plus per-digit decimal points into one shared segment bus and N digit-enable lines, and scans the digits with an internal refresh prescaler. It sits between the datapath that produces display values and the board's display pins, and generalises the fixed two-digit scanner to any digit count, refresh rate and enable polarity. Input values are captured once per frame, so a frame never shows a half-updated value.

## Interface
- `N_DIGITS`, default 4: number of digits; legal range 2..8.
- `DIV`, default 50000: clock cycles per digit slot; legal minimum 2.
- `COM_ACTIVE_LOW`, default 0: 0 drives the enabled digit's `com` bit to 1; 1 drives it to 0.
- `clock` input 1: single system clock; everything is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `digits` input 4*N_DIGITS: packed hex values; `digits[3:0]` is digit 0 (least significant, rightmost).
- `dp_in` input N_DIGITS: decimal point per digit; bit i belongs to digit i.
- `com` output N_DIGITS: digit enables; exactly one bit is active outside reset.
- `data_out` output 7: segments, active-high; bit 0 = a … bit 6 = g.
- `dp_out` output 1: decimal point for the currently enabled digit.
- `frame_tick` output 1: one-cycle pulse on the cycle the input snapshot loads.

## Operation
- Prescaler `cnt`, width $clog2(DIV):
  - counts 0..DIV-1, then wraps to 0;
  - `tick` is asserted when `cnt == DIV-1`.
- Digit index `idx`, 0..N_DIGITS-1:
  - advances by 1 on `tick`;
  - wraps from N_DIGITS-1 to 0; values ≥ N_DIGITS are never reached.
- Snapshot registers `snap_d` (4*N_DIGITS bits) and `snap_dp` (N_DIGITS bits):
  - load `digits` and `dp_in` on a `tick` where `idx == N_DIGITS-1` (frame wrap);
  - hold otherwise;
  - `frame_tick` is registered and high for exactly the cycle after that load edge.
- Decode from `snap_d` nibble `idx`, as {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07;
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- All outputs are registered. Each cycle:
  - `com` = one-hot(`idx`), inverted if COM_ACTIVE_LOW;
  - `data_out` = decode of nibble `idx`;
  - `dp_out` = `snap_dp[idx]`.
- Reset:
  - `cnt`=0, `idx`=0, `snap_d`=0, `snap_dp`=0;
  - `com` all inactive (all 0, or all 1 if COM_ACTIVE_LOW);
  - `data_out`=0, `dp_out`=0, `frame_tick`=0.
- Reset asserted mid-frame: state returns to the reset values on the next edge; the partially scanned frame and the snapshot are discarded.

## Timing
- Output latency is 1 cycle from the `idx` and snapshot registers.
  - First cycle after reset release: `com` enables digit 0 and shows the snapshot value 0 (3F).
- Each digit is enabled for exactly DIV cycles; a frame is N_DIGITS*DIV cycles.
- Reset released at edge 0:
  - `cnt` reaches DIV-1 in cycle DIV-1;
  - `idx`=1 from edge DIV, and `com` moves to digit 1 one edge later.
- Snapshot loads at the edge ending the last digit slot. The new values are first visible on digit 0 one cycle later, coincident with `frame_tick`=1.
- `digits` changing at any other time has no visible effect until the next frame wrap.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digit i (i ≥ 1) is blanked when `snap_d` nibbles i..N_DIGITS-1 are all 0.
  - A blanked digit drives `data_out`=0; `dp_out` still follows `snap_dp[i]`, and `com` scanning is unchanged.
  - Digit 0 is never blanked.
  - The blank mask is computed from the snapshot, so it is constant within a frame.
- `SEG_LZ_BLANK_EN` undefined: every digit always shows its decoded value, including leading zeros; no blanking logic is built.

## Test plan
- Reset and scan, with N_DIGITS=4, DIV=4:
  - hold `reset` 3 cycles → `com`=0000 and `data_out`=00 during reset;
  - after release `com` cycles 0001→0010→0100→1000 every 4 cycles, wrapping back to 0001.
- Snapshot, `digits`=16'h12AF, `dp_in`=4'b0100:
  - `frame_tick` pulses 16 cycles after release;
  - next frame shows digit 0=71, 1=77, 2=5B with `dp_out`=1, 3=06.
- Mid-frame change: change `digits` to 16'h0000 while digit 1 is enabled → remaining digits of the current frame still show 12AF; 0000 appears only after the next `frame_tick`.
- Polarity: with COM_ACTIVE_LOW=1 → reset `com`=1111; scan pattern is 1110→1101→1011→0111.
- Leading-zero blanking, `SEG_LZ_BLANK_EN` defined, `digits`=16'h0050:
  - digits 3 and 2 show `data_out`=00;
  - digit 1=6D, digit 0=3F.
  - Macro undefined → digits 3 and 2 show 3F.
- Reset mid-frame: assert `reset` while digit 2 is enabled → next edge `com` is inactive and the snapshot is 0; after release the scan restarts at digit 0 showing 3F.

Source files
------------

// File: rtl/seg_scan_ndigit.sv
// seg_scan_ndigit: multiplexed driver for an N-digit common-electrode 7-segment display.
// A prescaler sets the slot length, a digit index scans the digits, and the hex values
// are snapshotted once per frame so a frame never shows a half-updated value.
// Optional feature: define SEG_LZ_BLANK_EN to enable leading-zero suppression.
module seg_scan_ndigit #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned DIV            = 50000,
    parameter bit          COM_ACTIVE_LOW = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [N_DIGITS-1:0]   com,
    output logic [6:0]            data_out,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int unsigned CntW = $clog2(DIV);
    localparam int unsigned IdxW = $clog2(N_DIGITS);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ComIdle = {N_DIGITS{COM_ACTIVE_LOW}};

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*N_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                  load_q;
    logic [N_DIGITS-1:0]   com_q, com_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_tick_q;

    logic                  tick;
    logic                  load;
    logic [3:0]            nib;
    logic                  blank_sel;

    // Hex to segment pattern, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

`ifdef SEG_LZ_BLANK_EN
    logic [N_DIGITS-1:0] blank_mask;
    logic                upper_zero;

    // Blank digit i when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_mask = '0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero && (snap_dig_q[4*i +: 4] == 4'h0);
            blank_mask[i] = upper_zero;
        end
    end

    // Blank flag for the digit being scanned.
    always_comb begin
        blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) blank_sel = blank_mask[i];
        end
    end
`else
    assign blank_sel = 1'b0;
`endif

    // Prescaler, digit index and frame snapshot next-state.
    always_comb begin
        tick       = (cnt_q == CntMax);
        load       = tick && (idx_q == IdxMax);
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        if (tick) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
        if (load) begin
            snap_dig_d = digits;
            snap_dp_d  = dp_in;
        end
    end

    // Output next-state from the current index and snapshot.
    always_comb begin
        nib   = 4'h0;
        com_d = '0;
        dp_d  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib      = snap_dig_q[4*i +: 4];
                com_d[i] = 1'b1;
                dp_d     = snap_dp_q[i];
            end
        end
        if (COM_ACTIVE_LOW) com_d = ~com_d;
        seg_d = blank_sel ? 7'h00 : hex_to_seg(nib);
    end

    // State and registered outputs; reset discards any partial frame and the snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            load_q       <= 1'b0;
            com_q        <= ComIdle;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            load_q       <= load;
            com_q        <= com_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            // Delayed one extra edge so the pulse lines up with digit 0 of the new frame.
            frame_tick_q <= load_q;
        end
    end

    assign com        = com_q;
    assign data_out   = seg_q;
    assign dp_out     = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ndigit.sv
// Directed bench for seg_scan_ndigit with N_DIGITS=4, DIV=4; a second instance
// with COM_ACTIVE_LOW=1 shares the inputs to cover enable polarity.
module tb_seg_scan_ndigit;

    localparam int unsigned NDig = 4;
    localparam int unsigned Div  = 4;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LzBlank = 1'b1;
`else
    localparam bit LzBlank = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  com, com_n;
    logic [6:0]  data_out, data_out_n;
    logic        dp_out, dp_out_n;
    logic        frame_tick, frame_tick_n;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_ndigit #(.N_DIGITS(NDig), .DIV(Div), .COM_ACTIVE_LOW(1'b0)) dut (
        .clock(clock), .reset(reset), .digits(digits), .dp_in(dp_in),
        .com(com), .data_out(data_out), .dp_out(dp_out), .frame_tick(frame_tick)
    );

    seg_scan_ndigit #(.N_DIGITS(NDig), .DIV(Div), .COM_ACTIVE_LOW(1'b1)) dut_n (
        .clock(clock), .reset(reset), .digits(digits), .dp_in(dp_in),
        .com(com_n), .data_out(data_out_n), .dp_out(dp_out_n), .frame_tick(frame_tick_n)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        digits = 16'h12AF;
        dp_in  = 4'b0100;
        reset  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (com !== 4'b0000) begin n_err++;
                $display("FAIL reset_com c=%0d got=%b exp=0000", c, com); end
            n_cmp++; if (data_out !== 7'h00) begin n_err++;
                $display("FAIL reset_seg c=%0d got=%h exp=00", c, data_out); end
            n_cmp++; if (dp_out !== 1'b0) begin n_err++;
                $display("FAIL reset_dp c=%0d got=%b exp=0", c, dp_out); end
            n_cmp++; if (frame_tick !== 1'b0) begin n_err++;
                $display("FAIL reset_tick c=%0d got=%b exp=0", c, frame_tick); end
            n_cmp++; if (com_n !== 4'b1111) begin n_err++;
                $display("FAIL reset_com_n c=%0d got=%b exp=1111", c, com_n); end
        end
        reset = 1'b0;
    endtask

    // First frame after release: snapshot is still zero.
    task automatic test_scan();
        logic [3:0] exp_com;
        logic [6:0] exp_seg;
        int d;
        for (int k = 1; k <= 16; k++) begin
            step();
            d       = (k - 1) / 4;
            exp_com = 4'(4'b0001 << d);
            exp_seg = (LzBlank && d != 0) ? 7'h00 : 7'h3F;
            n_cmp++; if (com !== exp_com) begin n_err++;
                $display("FAIL scan_com k=%0d got=%b exp=%b", k, com, exp_com); end
            n_cmp++; if (com_n !== ~exp_com) begin n_err++;
                $display("FAIL scan_com_n k=%0d got=%b exp=%b", k, com_n, ~exp_com); end
            n_cmp++; if (data_out !== exp_seg) begin n_err++;
                $display("FAIL scan_seg k=%0d got=%h exp=%h", k, data_out, exp_seg); end
            n_cmp++; if (dp_out !== 1'b0) begin n_err++;
                $display("FAIL scan_dp k=%0d got=%b exp=0", k, dp_out); end
            n_cmp++; if (frame_tick !== 1'b0) begin n_err++;
                $display("FAIL scan_tick k=%0d got=%b exp=0", k, frame_tick); end
        end
    endtask

    // Frame showing 12AF; digits go to 0000 mid-frame without visible effect.
    task automatic test_snapshot();
        logic [6:0] segs [4];
        logic [3:0] exp_com;
        int d;
        segs = '{7'h71, 7'h77, 7'h5B, 7'h06};
        for (int k = 17; k <= 32; k++) begin
            step();
            d       = ((k - 1) / 4) % 4;
            exp_com = 4'(4'b0001 << d);
            n_cmp++; if (com !== exp_com) begin n_err++;
                $display("FAIL snap_com k=%0d got=%b exp=%b", k, com, exp_com); end
            n_cmp++; if (data_out !== segs[d]) begin n_err++;
                $display("FAIL snap_seg k=%0d got=%h exp=%h", k, data_out, segs[d]); end
            n_cmp++; if (dp_out !== 1'(d == 2)) begin n_err++;
                $display("FAIL snap_dp k=%0d got=%b exp=%b", k, dp_out, d == 2); end
            n_cmp++; if (frame_tick !== 1'(k == 17)) begin n_err++;
                $display("FAIL snap_tick k=%0d got=%b exp=%b", k, frame_tick, k == 17); end
            if (k == 21) digits = 16'h0000;
        end
    endtask

    // Frame showing 0000 loaded at the previous wrap.
    task automatic test_zero_frame();
        logic [6:0] exp_seg;
        int d;
        for (int k = 33; k <= 48; k++) begin
            step();
            d       = ((k - 1) / 4) % 4;
            exp_seg = (LzBlank && d != 0) ? 7'h00 : 7'h3F;
            n_cmp++; if (com !== 4'(4'b0001 << d)) begin n_err++;
                $display("FAIL zero_com k=%0d got=%b digit=%0d", k, com, d); end
            n_cmp++; if (data_out !== exp_seg) begin n_err++;
                $display("FAIL zero_seg k=%0d got=%h exp=%h", k, data_out, exp_seg); end
            n_cmp++; if (frame_tick !== 1'(k == 33)) begin n_err++;
                $display("FAIL zero_tick k=%0d got=%b exp=%b", k, frame_tick, k == 33); end
            if (k == 33) digits = 16'h0050;
        end
    endtask

    // 0050: upper two digits blank only when suppression is built.
    task automatic test_lz_blank();
        logic [6:0] segs [4];
        int d;
        segs = '{7'h3F, 7'h6D, (LzBlank ? 7'h00 : 7'h3F), (LzBlank ? 7'h00 : 7'h3F)};
        for (int k = 49; k <= 64; k++) begin
            step();
            d = ((k - 1) / 4) % 4;
            n_cmp++; if (data_out !== segs[d]) begin n_err++;
                $display("FAIL lz_seg k=%0d got=%h exp=%h", k, data_out, segs[d]); end
            n_cmp++; if (dp_out !== 1'(d == 2)) begin n_err++;
                $display("FAIL lz_dp k=%0d got=%b exp=%b", k, dp_out, d == 2); end
            n_cmp++; if (frame_tick !== 1'(k == 49)) begin n_err++;
                $display("FAIL lz_tick k=%0d got=%b exp=%b", k, frame_tick, k == 49); end
        end
        digits = 16'h1234;
    endtask

    // Reset while digit 2 is lit: snapshot discarded, scan restarts at digit 0.
    task automatic test_reset_midframe();
        logic [6:0] exp_seg;
        int d;
        for (int k = 65; k <= 73; k++) step();
        n_cmp++; if (com !== 4'b0100) begin n_err++;
            $display("FAIL mid_pre_com got=%b exp=0100", com); end
        reset = 1'b1;
        step();
        n_cmp++; if (com !== 4'b0000) begin n_err++;
            $display("FAIL mid_rst_com got=%b exp=0000", com); end
        n_cmp++; if (com_n !== 4'b1111) begin n_err++;
            $display("FAIL mid_rst_com_n got=%b exp=1111", com_n); end
        n_cmp++; if (data_out !== 7'h00) begin n_err++;
            $display("FAIL mid_rst_seg got=%h exp=00", data_out); end
        n_cmp++; if (dp_out !== 1'b0) begin n_err++;
            $display("FAIL mid_rst_dp got=%b exp=0", dp_out); end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            d       = (k - 1) / 4;
            exp_seg = (LzBlank && d != 0) ? 7'h00 : 7'h3F;
            n_cmp++; if (com !== 4'(4'b0001 << d)) begin n_err++;
                $display("FAIL mid_scan_com k=%0d got=%b digit=%0d", k, com, d); end
            n_cmp++; if (data_out !== exp_seg) begin n_err++;
                $display("FAIL mid_scan_seg k=%0d got=%h exp=%h", k, data_out, exp_seg); end
            n_cmp++; if (dp_out !== 1'b0) begin n_err++;
                $display("FAIL mid_scan_dp k=%0d got=%b exp=0", k, dp_out); end
            n_cmp++; if (frame_tick !== 1'b0) begin n_err++;
                $display("FAIL mid_scan_tick k=%0d got=%b exp=0", k, frame_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_zero_frame();
        test_lz_blank();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
